// File: rtl/miner_pkg.sv
// Shared types and defaults for the block-header framer.
// The CHECK state exists only when HEADER_CHECKSUM_EN is defined.
package miner_pkg;

  localparam int unsigned HEADER_BYTES_DEFAULT   = 80;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 500000;
  localparam int unsigned BYTE_W                 = 8;
  localparam int unsigned COUNT_W                = 7;

`ifdef HEADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    FULL  = 2'd2,
    CHECK = 2'd3
  } framer_state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FULL = 2'd2
  } framer_state_t;
`endif

  // A frame is in progress while bytes (or the trailing checksum) are awaited.
  function automatic logic state_busy(input framer_state_t s);
`ifdef HEADER_CHECKSUM_EN
    return (s == RECV) || (s == CHECK);
`else
    return (s == RECV);
`endif
  endfunction

endpackage

// File: rtl/framer_timeout.sv
// Inter-byte idle timer: loadable down-counter, saturating at zero.
module framer_timeout
  import miner_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;

  // Clear wins over load; decrement only while idle cycles are being counted.
  always_comb begin
    count_nxt = count_q;
    if (clear) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = CNT_W'(TIMEOUT_CYCLES);
    end else if (enable && (count_q != '0)) begin
      count_nxt = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      expired <= 1'b1;
    end else begin
      count_q <= count_nxt;
      expired <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/header_framer.sv
// Assembles HEADER_BYTES UART bytes MSB-first into one block header.
// Define HEADER_CHECKSUM_EN to require a trailing XOR byte before release.
module header_framer
  import miner_pkg::*;
#(
  parameter int unsigned HEADER_BYTES   = HEADER_BYTES_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_ready,
  input  logic                      header_ack,
  output logic [8*HEADER_BYTES-1:0] header_data,
  output logic                      header_valid,
  output logic                      frame_error,
  output logic [6:0]                byte_count,
  output logic                      busy
);

  localparam int unsigned HDR_W = BYTE_W * HEADER_BYTES;
  localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(HEADER_BYTES - 1);

  framer_state_t      state_q;
  framer_state_t      state_nxt;
  logic [HDR_W-1:0]   header_nxt;
  logic [COUNT_W-1:0] count_nxt;
  logic               error_nxt;
  logic               store;
  logic [COUNT_W-1:0] store_idx;
  logic               tmo_load;
  logic               tmo_clear;
  logic               tmo_enable;
  logic               tmo_expired;
`ifdef HEADER_CHECKSUM_EN
  logic [BYTE_W-1:0]  xor_q;
  logic [BYTE_W-1:0]  xor_nxt;
`endif

  framer_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (tmo_clear),
    .load   (tmo_load),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  // Next-state, byte placement and error decisions; rx_ready beats a timeout.
  always_comb begin
    state_nxt  = state_q;
    header_nxt = header_data;
    count_nxt  = byte_count;
    error_nxt  = 1'b0;
    store      = 1'b0;
    store_idx  = '0;
    tmo_load   = 1'b0;
    tmo_clear  = 1'b0;
    tmo_enable = state_busy(state_q) && !rx_ready;
`ifdef HEADER_CHECKSUM_EN
    xor_nxt    = xor_q;
`endif

    case (state_q)
      IDLE: begin
        if (rx_ready) begin
          store     = 1'b1;
          count_nxt = COUNT_W'(1);
          tmo_load  = 1'b1;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (rx_ready) begin
          store     = 1'b1;
          store_idx = byte_count;
          count_nxt = byte_count + COUNT_W'(1);
          tmo_load  = 1'b1;
          if (byte_count == LAST_IDX) begin
`ifdef HEADER_CHECKSUM_EN
            state_nxt = CHECK;
`else
            state_nxt = FULL;
`endif
          end
        end else if (tmo_expired) begin
          error_nxt = 1'b1;
          count_nxt = '0;
          tmo_clear = 1'b1;
          state_nxt = IDLE;
        end
      end
`ifdef HEADER_CHECKSUM_EN
      CHECK: begin
        if (rx_ready && (rx_data == xor_q)) begin
          state_nxt = FULL;
        end else if (rx_ready || tmo_expired) begin
          error_nxt = 1'b1;
          count_nxt = '0;
          tmo_clear = 1'b1;
          state_nxt = IDLE;
        end
      end
`endif
      FULL: begin
        if (header_ack && rx_ready) begin
          store     = 1'b1;
          count_nxt = COUNT_W'(1);
          tmo_load  = 1'b1;
          state_nxt = RECV;
        end else if (header_ack) begin
          count_nxt = '0;
          tmo_clear = 1'b1;
          state_nxt = IDLE;
        end else if (rx_ready) begin
          error_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Byte k of the frame lands k bytes below the top of header_data.
    if (store) begin
      for (int unsigned i = 0; i < HEADER_BYTES; i++) begin
        if (store_idx == COUNT_W'(i)) begin
          header_nxt[HDR_W - BYTE_W*(i+1) +: BYTE_W] = rx_data;
        end
      end
`ifdef HEADER_CHECKSUM_EN
      xor_nxt = (store_idx == '0) ? rx_data : (xor_q ^ rx_data);
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      header_data  <= '0;
      header_valid <= 1'b0;
      frame_error  <= 1'b0;
      byte_count   <= '0;
      busy         <= 1'b0;
`ifdef HEADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_nxt;
      header_data  <= header_nxt;
      header_valid <= (state_nxt == FULL);
      frame_error  <= error_nxt;
      byte_count   <= count_nxt;
      busy         <= state_busy(state_nxt);
`ifdef HEADER_CHECKSUM_EN
      xor_q        <= xor_nxt;
`endif
    end
  end

endmodule
